// File: rtl/xoodoo_perm_ctrl_sca.sv
// Pass sequencer for a masked Xoodoo round core: loads two input shares, fetches fresh
// randomness before every pass, waits out the core latency and captures the output shares.
module xoodoo_perm_ctrl_sca #(
  parameter int ROUND_PER_CYCLE = 1,
  parameter int NUM_ROUNDS      = 12,
  parameter int ROUND_LAT       = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [383:0] din0,
  input  logic [383:0] din1,
  output logic         busy,
  output logic         done,
  output logic [383:0] dout0,
  output logic [383:0] dout1,
  output logic         rnd_req,
  input  logic         rnd_valid,
  input  logic [383:0] rnd0,
  input  logic [383:0] rnd1,
  output logic [383:0] core_in0,
  output logic [383:0] core_in1,
  output logic [383:0] core_rs0,
  output logic [383:0] core_rs1,
  output logic [12:0]  core_j,
  input  logic [383:0] core_out0,
  input  logic [383:0] core_out1
);

  localparam int NUM_PASSES = NUM_ROUNDS / ROUND_PER_CYCLE;
  localparam int LAT_W      = $clog2(ROUND_LAT + 2);

  typedef enum logic [1:0] {IDLE, RND, RUN, DONE} state_e;

  state_e             state_q, state_d;
  logic [383:0]       sh0_q, sh0_d, sh1_q, sh1_d;
  logic [383:0]       rs0_q, rs0_d, rs1_q, rs1_d;
  logic [3:0]         pass_q, pass_d;
  logic [LAT_W-1:0]   lat_q, lat_d;

  // NOTE: share and randomness registers are plain flops, so they take the reset too;
  // a mid-run rst must not leave stale shares visible on dout/core_in.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh0_q   <= '0;
      sh1_q   <= '0;
      rs0_q   <= '0;
      rs1_q   <= '0;
      pass_q  <= '0;
      lat_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      rs0_q   <= rs0_d;
      rs1_q   <= rs1_d;
      pass_q  <= pass_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    // NOTE: hold-value defaults first, so no branch can infer a latch.
    state_d = state_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    rs0_d   = rs0_q;
    rs1_d   = rs1_q;
    pass_d  = pass_q;
    lat_d   = lat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sh0_d   = din0;
          sh1_d   = din1;
          pass_d  = '0;
          state_d = RND;
        end
      end
      RND: begin
        if (rnd_valid) begin
          rs0_d   = rnd0;
          rs1_d   = rnd1;
          lat_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        lat_d = lat_q + LAT_W'(1);
        if (lat_q == LAT_W'(ROUND_LAT)) begin
          sh0_d   = core_out0;
          sh1_d   = core_out1;
          pass_d  = pass_q + 4'd1;
          state_d = (pass_q == 4'(NUM_PASSES - 1)) ? DONE : RND;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shares stay in separate registers all the way out; nothing here ever XORs them.
  assign busy     = (state_q == RND) || (state_q == RUN);
  assign done     = (state_q == DONE);
  assign rnd_req  = (state_q == RND);
  assign dout0    = sh0_q;
  assign dout1    = sh1_q;
  assign core_in0 = sh0_q;
  assign core_in1 = sh1_q;
  assign core_rs0 = rs0_q;
  assign core_rs1 = rs1_q;
  assign core_j   = 13'h1 << (pass_q * ROUND_PER_CYCLE);

endmodule

// File: tb/tb_xoodoo_perm_ctrl_sca.sv
// Bench for xoodoo_perm_ctrl_sca: behavioural masked round core with latency, golden
// Xoodoo[12], table of permutations plus reset / start-poke / two-rounds-per-pass sequences.
module tb_xoodoo_perm_ctrl_sca;

  localparam int LAT = 2;
  localparam int CW  = 4 * 384 + 13;
  localparam logic [383:0] JUNK = {12{32'h5A5A_C3C3}};

  typedef struct {
    logic [383:0] x;
    logic [383:0] m;
    int           stall_pass;
    int           stall_len;
    int           exp_cycle;
  } vec_t;

  typedef struct {
    logic [383:0] res;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start, rnd_valid, start_b, rnd_valid_b;
  logic [383:0] din0, din1, rnd0, rnd1;
  logic         busy, done, rnd_req, busy_b, done_b, rnd_req_b;
  logic [383:0] dout0, dout1, core_in0, core_in1, core_rs0, core_rs1, core_out0, core_out1;
  logic [383:0] dout0_b, dout1_b, core_in0_b, core_in1_b, core_rs0_b, core_rs1_b;
  logic [383:0] core_out0_b, core_out1_b;
  logic [12:0]  core_j, core_j_b;

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   start_cyc;
  exp_t sb[$];
  vec_t vecs[7];

  always @(posedge clk) cyc <= cyc + 1;

  xoodoo_perm_ctrl_sca dut (
    .clk(clk), .rst(rst), .start(start), .din0(din0), .din1(din1),
    .busy(busy), .done(done), .dout0(dout0), .dout1(dout1),
    .rnd_req(rnd_req), .rnd_valid(rnd_valid), .rnd0(rnd0), .rnd1(rnd1),
    .core_in0(core_in0), .core_in1(core_in1), .core_rs0(core_rs0), .core_rs1(core_rs1),
    .core_j(core_j), .core_out0(core_out0), .core_out1(core_out1)
  );

  xoodoo_perm_ctrl_sca #(.ROUND_PER_CYCLE(2), .NUM_ROUNDS(12), .ROUND_LAT(2)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .din0(din0), .din1(din1),
    .busy(busy_b), .done(done_b), .dout0(dout0_b), .dout1(dout1_b),
    .rnd_req(rnd_req_b), .rnd_valid(rnd_valid_b), .rnd0(rnd0), .rnd1(rnd1),
    .core_in0(core_in0_b), .core_in1(core_in1_b), .core_rs0(core_rs0_b), .core_rs1(core_rs1_b),
    .core_j(core_j_b), .core_out0(core_out0_b), .core_out1(core_out1_b)
  );

  // ---------------- Xoodoo reference ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] rc(input int i);
    case (i)
      0: return 32'h058;  1: return 32'h038;  2: return 32'h3C0;  3: return 32'h0D0;
      4: return 32'h120;  5: return 32'h014;  6: return 32'h060;  7: return 32'h02C;
      8: return 32'h380;  9: return 32'h0F0; 10: return 32'h1A0; default: return 32'h012;
    endcase
  endfunction

  function automatic logic [383:0] xround(input logic [383:0] s, input logic [31:0] c);
    logic [31:0] a[3][4];
    logic [31:0] b[3][4];
    logic [31:0] p[4];
    logic [31:0] e[4];
    logic [31:0] t[4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = s[32*(x+4*y) +: 32];
    for (int x = 0; x < 4; x++) p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    for (int x = 0; x < 4; x++) e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ e[x];
    for (int x = 0; x < 4; x++) t[x] = a[1][(x+3)%4];
    for (int x = 0; x < 4; x++) begin a[1][x] = t[x]; a[2][x] = rotl(a[2][x], 11); end
    a[0][0] = a[0][0] ^ c;
    for (int x = 0; x < 4; x++) begin
      b[0][x] = ~a[1][x] & a[2][x];
      b[1][x] = ~a[2][x] & a[0][x];
      b[2][x] = ~a[0][x] & a[1][x];
    end
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) a[y][x] = a[y][x] ^ b[y][x];
    for (int x = 0; x < 4; x++) t[x] = rotl(a[2][(x+2)%4], 8);
    for (int x = 0; x < 4; x++) begin a[1][x] = rotl(a[1][x], 1); a[2][x] = t[x]; end
    for (int y = 0; y < 3; y++) for (int x = 0; x < 4; x++) r[32*(x+4*y) +: 32] = a[y][x];
    return r;
  endfunction

  function automatic logic [383:0] golden(input logic [383:0] x);
    logic [383:0] s = x;
    for (int i = 0; i < 12; i++) s = xround(s, rc(i));
    return s;
  endfunction

  // Masked core model: applies rpc rounds starting at the one-hot index, re-masks with rs.
  function automatic logic [767:0] core_fn(input logic [383:0] i0, i1, r0, r1,
                                           input logic [12:0] j, input int rpc);
    int k = -1;
    logic [383:0] s = i0 ^ i1;
    logic [383:0] m = r0 ^ {r1[191:0], r1[383:192]};
    for (int i = 0; i < 13; i++) if (j[i] && k < 0) k = i;
    if (k >= 0) for (int r = 0; r < rpc; r++) if (k + r < 12) s = xround(s, rc(k + r));
    return {s ^ m, m};
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Outputs are only valid once the core inputs have been stable for LAT cycles.
  logic [CW-1:0]  cur_a, last_a, cur_b, last_b;
  int             cnt_a = 0, cnt_b = 0;
  logic [767:0]   out_a, out_b;
  assign cur_a = {core_in0, core_in1, core_rs0, core_rs1, core_j};
  assign cur_b = {core_in0_b, core_in1_b, core_rs0_b, core_rs1_b, core_j_b};

  always @(posedge clk) begin
    cnt_a  <= (cur_a == last_a) ? cnt_a + 1 : 1;
    last_a <= cur_a;
    cnt_b  <= (cur_b == last_b) ? cnt_b + 1 : 1;
    last_b <= cur_b;
  end

  always_comb begin
    out_a = core_fn(core_in0, core_in1, core_rs0, core_rs1, core_j, 1);
    if (!((cur_a == last_a) && cnt_a >= LAT)) out_a[767:384] = out_a[767:384] ^ JUNK;
    out_b = core_fn(core_in0_b, core_in1_b, core_rs0_b, core_rs1_b, core_j_b, 2);
    if (!((cur_b == last_b) && cnt_b >= LAT)) out_b[767:384] = out_b[767:384] ^ JUNK;
  end
  assign core_out0   = out_a[767:384];
  assign core_out1   = out_a[383:0];
  assign core_out0_b = out_b[767:384];
  assign core_out1_b = out_b[383:0];

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_op(input vec_t v, input bit poke, input bit no_wait);
    int pass_idx = -1, run_len = 0, max_run = 0, j_bad = 0, hold_bad = 0, stalls = 0;
    int c = 0, extra = 0;
    bit got = 0, prev_req = 0, prev_run = 0;
    logic [383:0] h_in0, h_in1, h_rs0, h_rs1, fin0, fin1;
    exp_t e;
    if (!no_wait) @(negedge clk);
    din0 = v.x ^ v.m; din1 = v.m; start = 1'b1; rnd_valid = 1'b1; start_cyc = cyc;
    e.res = golden(v.x); e.cyc = v.exp_cycle; sb.push_back(e);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      c = cyc - start_cyc;
      start = poke && (c == 1 || c == 3 || c == 6);
      din0 = rand384(); din1 = rand384(); rnd0 = rand384(); rnd1 = rand384();
      if (rnd_req && !prev_req) begin pass_idx++; run_len = 0; end
      prev_req = rnd_req;
      if (rnd_req) begin run_len++; if (run_len > max_run) max_run = run_len; end
      if (busy && pass_idx >= 0 && core_j !== (13'h1 << pass_idx)) j_bad++;
      if (busy && !rnd_req) begin
        if (!prev_run) begin
          h_in0 = core_in0; h_in1 = core_in1; h_rs0 = core_rs0; h_rs1 = core_rs1;
        end else if ({core_in0, core_in1, core_rs0, core_rs1} !== {h_in0, h_in1, h_rs0, h_rs1})
          hold_bad++;
      end
      prev_run = busy && !rnd_req;
      if (rnd_req && pass_idx == v.stall_pass && stalls < v.stall_len) begin
        rnd_valid = 1'b0; stalls++;
      end else if (rnd_req) rnd_valid = 1'b1;
      else rnd_valid = 1'($urandom_range(0, 1));
      if (done) begin
        got = 1; e = sb.pop_front(); fin0 = dout0; fin1 = dout1;
        check("result", dout0 ^ dout1, e.res);
        check_int("done_cycle", c, e.cyc);
        check_int("busy_in_done", int'(busy), 0);
        check_int("passes", pass_idx + 1, 12);
        check_int("rnd_req_run", max_run, v.stall_len + 1);
        check_int("core_j_bad_cycles", j_bad, 0);
        check_int("run_inputs_unstable", hold_bad, 0);
        start = poke;
      end
    end
    check_int("done_seen", int'(got), 1);
    if (!got) sb.delete();
    else begin
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        start = 1'b0; rnd_valid = 1'($urandom_range(0, 1)); rnd0 = rand384(); rnd1 = rand384();
        if (busy || done) extra++;
      end
      check_int("idle_after_done", extra, 0);
      check("dout0_hold", dout0, fin0);
      check("dout1_hold", dout1, fin1);
    end
  endtask

  task automatic run_b(input logic [383:0] x, input logic [383:0] m);
    logic [12:0] jseq[$];
    logic [12:0] jexp[6];
    bit got = 0, prev = 0;
    exp_t e;
    jexp = '{13'h001, 13'h004, 13'h010, 13'h040, 13'h100, 13'h400};
    @(negedge clk);
    din0 = x ^ m; din1 = m; start_b = 1'b1; start_cyc = cyc;
    e.res = golden(x); e.cyc = 25; sb.push_back(e);
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      start_b = 1'b0; rnd0 = rand384(); rnd1 = rand384();
      if (rnd_req_b && !prev) jseq.push_back(core_j_b);
      prev = rnd_req_b;
      if (done_b) begin
        got = 1; e = sb.pop_front();
        check("b_result", dout0_b ^ dout1_b, e.res);
        check_int("b_done_cycle", cyc - start_cyc, e.cyc);
      end
    end
    check_int("b_done_seen", int'(got), 1);
    check_int("b_passes", jseq.size(), 6);
    for (int i = 0; i < jseq.size() && i < 6; i++) check("b_core_j", 384'(jseq[i]), 384'(jexp[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [383:0] x;
    start = 1'b1; start_b = 1'b0; rnd_valid = 1'b1; rnd_valid_b = 1'b1;
    din0 = rand384(); din1 = rand384(); rnd0 = rand384(); rnd1 = rand384();
    x = rand384();
    vecs[0] = '{x: '0,        m: rand384(), stall_pass: -1, stall_len: 0, exp_cycle: 49};
    vecs[1] = '{x: x,         m: rand384(), stall_pass: -1, stall_len: 0, exp_cycle: 49};
    vecs[2] = '{x: rand384(), m: '0,        stall_pass: -1, stall_len: 0, exp_cycle: 49};
    vecs[3] = '{x: x,         m: rand384(), stall_pass: -1, stall_len: 0, exp_cycle: 49};
    vecs[4] = '{x: rand384(), m: rand384(), stall_pass: 3,  stall_len: 5, exp_cycle: 54};
    vecs[5] = '{x: '1,        m: rand384(), stall_pass: 0,  stall_len: 2, exp_cycle: 51};
    vecs[6] = '{x: rand384(), m: rand384(), stall_pass: 11, stall_len: 1, exp_cycle: 50};

    // Reset state, with start held high throughout reset
    repeat (3) @(negedge clk);
    check_int("rst_busy", int'(busy), 0);
    check_int("rst_done", int'(done), 0);
    check_int("rst_rnd_req", int'(rnd_req), 0);
    check("rst_dout0", dout0, '0);
    check("rst_dout1", dout1, '0);
    check("rst_core_in0", core_in0, '0);
    check("rst_core_rs1", core_rs1, '0);
    check("rst_core_j", 384'(core_j), 384'(13'h001));
    check_int("rst_busy_b", int'(busy_b), 0);
    rst = 1'b0;
    run_op(vecs[0], 1'b0, 1'b1);
    for (int i = 1; i < 7; i++) run_op(vecs[i], 1'b0, 1'b0);

    // start pulses in RND, RUN and DONE must be ignored
    run_op(vecs[2], 1'b1, 1'b0);

    // Reset during the RUN phase of pass 6, then restart on the very next cycle
    @(negedge clk);
    din0 = vecs[4].x ^ vecs[4].m; din1 = vecs[4].m; start = 1'b1; rnd_valid = 1'b1; start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
    repeat (26) @(negedge clk);
    check_int("pre_rst_cycle", cyc - start_cyc, 27);
    check_int("pre_rst_busy", int'(busy), 1);
    check_int("pre_rst_rnd_req", int'(rnd_req), 0);
    check("pre_rst_core_j", 384'(core_j), 384'(13'h040));
    rst = 1'b1;
    @(negedge clk);
    check_int("mid_rst_busy", int'(busy), 0);
    check_int("mid_rst_done", int'(done), 0);
    check_int("mid_rst_rnd_req", int'(rnd_req), 0);
    check("mid_rst_dout0", dout0, '0);
    check("mid_rst_dout1", dout1, '0);
    check("mid_rst_core_in1", core_in1, '0);
    check("mid_rst_core_rs0", core_rs0, '0);
    check("mid_rst_core_j", 384'(core_j), 384'(13'h001));
    rst = 1'b0;
    run_op(vecs[4], 1'b0, 1'b1);

    // Two rounds per pass
    run_b(vecs[6].x, rand384());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
